// File: rtl/datapath_pkg.sv
// Shared encodings for the 4-bit x/y datapath and its microcoded sequencer.
package datapath_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDY  = 4'h1;
  localparam logic [3:0] OP_MOVX = 4'h2;
  localparam logic [3:0] OP_NOTX = 4'h3;
  localparam logic [3:0] OP_ADDX = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JNZ  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_NONE  = 2'd0;
  localparam logic [1:0] ALU_NOT   = 2'd1;
  localparam logic [1:0] ALU_ADD   = 2'd2;
  localparam logic [1:0] ALU_PASSY = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: control word, branch decision and
// halt/illegal classification for the instruction currently in EXEC.
module seq_decode
  import datapath_pkg::*;
(
  input  logic       exec,
  input  logic [7:0] ir,
  input  logic       zero,
  output logic [3:0] imm,
  output logic [1:0] op_sel,
  output logic       en_x,
  output logic       en_y,
  output logic       y_sel,
  output logic       branch_taken,
  output logic       halt,
  output logic       illegal
);

  logic [3:0] opcode;
  assign opcode = ir[7:4];

  always_comb begin
    imm          = 4'd0;
    op_sel       = ALU_NONE;
    en_x         = 1'b0;
    en_y         = 1'b0;
    y_sel        = 1'b0;
    branch_taken = 1'b0;
    halt         = 1'b0;
    illegal      = 1'b0;
    if (exec) begin
      case (opcode)
        OP_NOP: ;
        OP_LDY: begin
          y_sel = 1'b1;
          en_y  = 1'b1;
          imm   = ir[3:0];
        end
        OP_MOVX: begin
          op_sel = ALU_PASSY;
          en_x   = 1'b1;
        end
        OP_NOTX: begin
          op_sel = ALU_NOT;
          en_x   = 1'b1;
        end
        OP_ADDX: begin
          op_sel = ALU_ADD;
          en_x   = 1'b1;
        end
        OP_JMP:  branch_taken = 1'b1;
        OP_JNZ:  branch_taken = ~zero;
        OP_JZ:   branch_taken = zero;
        OP_HALT: halt = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/datapath_seq.sv
// Microcoded sequencer: 16-entry program RAM, FETCH/EXEC loop with zero-flag
// branches, a step-limit watchdog and a start/busy/done handshake.
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       zero,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] pc,
  output logic [3:0] imm,
  output logic [1:0] op_sel,
  output logic       en_x,
  output logic       en_y,
  output logic       y_sel
);

  localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

  logic [7:0] prog_ram [16];
  state_t     state;
  logic [7:0] ir;
  logic [7:0] steps;
  logic       exec;
  logic       branch_taken;
  logic       halt;
  logic       illegal;

  assign exec = (state == ST_EXEC);
  assign busy = (state != ST_IDLE);

  seq_decode u_decode (
    .exec         (exec),
    .ir           (ir),
    .zero         (zero),
    .imm          (imm),
    .op_sel       (op_sel),
    .en_x         (en_x),
    .en_y         (en_y),
    .y_sel        (y_sel),
    .branch_taken (branch_taken),
    .halt         (halt),
    .illegal      (illegal)
  );

  // Program RAM is writable only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && state == ST_IDLE) begin
      prog_ram[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= 4'd0;
      ir    <= 8'd0;
      steps <= 8'd0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
            pc    <= 4'd0;
            steps <= 8'd0;
            err   <= 1'b0;
          end
        end
        ST_FETCH: begin
          ir <= prog_ram[pc];
          // Watchdog: the limit is checked before the next instruction runs.
          if (steps == STEP_LIMIT) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (halt || illegal) begin
            if (illegal) begin
              err <= 1'b1;
            end
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            steps <= steps + 8'd1;
            pc    <= branch_taken ? ir[3:0] : pc + 4'd1;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
